mux_scan_n: RTL and testbench

- Parametrised, registered N-to-1 channel selector with a valid/ready output stream.
- Successor to the fixed 8:1 16-bit selector in the matrix-vector datapath.
- Adds a single-shot manual select mode and an auto-scan mode. Auto-scan streams channels 0..len-1 out one beat per handshake, feeding row elements to the MAC stage.

---
 rtl/mux_scan_n_if.sv | 39 +++
 rtl/mux_scan_n.sv | 114 +++++++++++
 tb/tb_mux_scan_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: request/response bundle for the mux_scan_n channel selector.
// The slave modport is the selector; the master modport is its driver/consumer.
// When MUX_SCAN_CHAN_TAG_EN is defined the bundle also carries out_chan.
interface mux_scan_n_if #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 16
);
   localparam int SEL_W = $clog2(N_CH);

   logic [N_CH*DATA_W-1:0] data_in;
   logic [SEL_W-1:0]       sel_in;
   logic                   mode;
   logic [SEL_W:0]         scan_len;
   logic                   start;
   logic [DATA_W-1:0]      out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   busy;
   logic                   done;
`ifdef MUX_SCAN_CHAN_TAG_EN
   logic [SEL_W-1:0]       out_chan;
`endif

   modport slave (
      input  data_in, sel_in, mode, scan_len, start, out_ready,
      output out_data, out_valid, busy, done
`ifdef MUX_SCAN_CHAN_TAG_EN
      , output out_chan
`endif
   );

   modport master (
      output data_in, sel_in, mode, scan_len, start, out_ready,
      input  out_data, out_valid, busy, done
`ifdef MUX_SCAN_CHAN_TAG_EN
      , input out_chan
`endif
   );
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N:1 channel selector with manual and auto-scan modes
// and a valid/ready output stream. Define MUX_SCAN_CHAN_TAG_EN to also emit
// the index of the driven channel on out_chan.
module mux_scan_n #(
   parameter int N_CH   = 8,
   parameter int DATA_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   mux_scan_n_if.slave bus
);
   localparam int SEL_W = $clog2(N_CH);
   localparam logic [SEL_W:0] N_CH_C = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W:0] ONE    = (SEL_W+1)'(1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

   state_t            state, state_nxt;
   logic              scan_mode;
   logic [SEL_W-1:0]  sel_lat;
   logic [SEL_W:0]    len_lat;
   logic [SEL_W:0]    cnt;
   logic [SEL_W:0]    idx;
   logic [SEL_W:0]    len_eff;
   logic [DATA_W-1:0] chan_word;
   logic [DATA_W-1:0] data_reg;
   logic              valid_reg;
   logic              done_reg;
   logic              last_beat;
`ifdef MUX_SCAN_CHAN_TAG_EN
   logic [SEL_W-1:0]  chan_reg;
`endif

   // Length 0 or beyond the channel count means "scan everything".
   assign len_eff   = (bus.scan_len == '0 || bus.scan_len > N_CH_C) ? N_CH_C : bus.scan_len;
   assign idx       = scan_mode ? cnt : {1'b0, sel_lat};
   assign last_beat = (cnt + ONE) >= len_lat;

   // Channel mux; an index with no matching channel yields zero.
   always_comb begin
      chan_word = '0;
      for (int k = 0; k < N_CH; k++)
         if (idx == (SEL_W+1)'(k)) chan_word = bus.data_in[k*DATA_W +: DATA_W];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: valid is always 1 in WAIT, so out_ready alone completes the handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = LOAD;
         LOAD:    state_nxt = WAIT;
         WAIT:    if (bus.out_ready) state_nxt = (!scan_mode || last_beat) ? IDLE : LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   // Operation latches, scan counter and registered output beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_mode <= 1'b0;
         sel_lat   <= '0;
         len_lat   <= '0;
         cnt       <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
`ifdef MUX_SCAN_CHAN_TAG_EN
         chan_reg  <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               scan_mode <= bus.mode;
               sel_lat   <= bus.sel_in;
               len_lat   <= len_eff;
               cnt       <= '0;
            end
            LOAD: begin
               // data_in is sampled here, not when start was taken.
               data_reg  <= chan_word;
               valid_reg <= 1'b1;
`ifdef MUX_SCAN_CHAN_TAG_EN
               chan_reg  <= idx[SEL_W-1:0];
`endif
            end
            WAIT: if (bus.out_ready) begin
               valid_reg <= 1'b0;
               if (!scan_mode || last_beat) begin
                  done_reg <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_data  = data_reg;
   assign bus.out_valid = valid_reg;
   assign bus.done      = done_reg;
   assign bus.busy      = (state != IDLE);
`ifdef MUX_SCAN_CHAN_TAG_EN
   assign bus.out_chan  = chan_reg;
`endif
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed stimulus with a scoreboard queue; a negedge monitor
// pops expected beats on each handshake, checks beat hold under backpressure
// and the single-cycle done pulse.
module tb_mux_scan_n;
   localparam int N_CH = 8;
   localparam int DW   = 16;

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    chan;
      bit            last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   beat_t exp_q[$];

   bit            hold_pend = 0;
   logic [DW-1:0] hold_data = '0;
   bit            exp_done = 0;

   mux_scan_n_if #(.N_CH(N_CH), .DATA_W(DW)) bus ();

   mux_scan_n #(.N_CH(N_CH), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic [2:0] c, input bit l);
      beat_t b;
      b.data = d; b.chan = c; b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic set_chans();
      for (int k = 0; k < N_CH; k++) bus.data_in[k*DW +: DW] = 16'(16'hA000 + k);
   endtask

   task automatic go(input logic m, input logic [2:0] s, input logic [3:0] len);
      bus.mode = m; bus.sel_in = s; bus.scan_len = len; bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 200) begin cyc(); n++; end
      if (n >= 200) chk({name, "_timeout"}, 32'd1, 32'd0);
      cyc();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.out_valid && n < 50) begin cyc(); n++; end
      if (n >= 50) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   // Monitor: scoreboard pop on handshake, hold and done-pulse checks.
   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 0;
         exp_done  = 0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), 32'(hold_data));
         end
         if (exp_done) chk("done_pulse", 32'(bus.done), 32'd1);
         else          chk("done_low", 32'(bus.done), 32'd0);
         exp_done = 0;
         if (bus.out_valid && bus.out_ready) begin
            hold_pend = 0;
            if (exp_q.size() == 0) begin
               chk("extra_beat", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_data", 32'(bus.out_data), 32'(b.data));
`ifdef MUX_SCAN_CHAN_TAG_EN
               chk("beat_chan", 32'(bus.out_chan), 32'(b.chan));
`endif
               exp_done = b.last;
            end
         end else if (bus.out_valid) begin
            hold_pend = 1;
            hold_data = bus.out_data;
         end else begin
            hold_pend = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.mode = 1'b0; bus.sel_in = '0; bus.scan_len = '0;
      bus.out_ready = 1'b0;
      set_chans();
      rst = 1'b1;
      cyc(); cyc();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      cyc();

      // Manual select, channel 5, two-cycle latency.
      bus.out_ready = 1'b1;
      push_beat(16'hA005, 3'd5, 1);
      go(1'b0, 3'd5, 4'd0);
      chk("man_busy_load", 32'(bus.busy), 32'd1);
      chk("man_valid_load", 32'(bus.out_valid), 32'd0);
      cyc();
      chk("man_valid", 32'(bus.out_valid), 32'd1);
      chk("man_data", 32'(bus.out_data), 32'hA005);
      cyc();
      chk("man_done", 32'(bus.done), 32'd1);
      chk("man_idle", 32'(bus.busy), 32'd0);
      cyc();
      chk("man_busy_after", 32'(bus.busy), 32'd0);

      // Full scan (len 0) with out_ready pattern 0,0,1.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 8; k++) push_beat(16'(16'hA000 + k), 3'(k), k == 7);
      go(1'b1, 3'd0, 4'd0);
      for (int n = 0; n < 150 && bus.busy; n++) begin
         bus.out_ready = (n % 3 == 2);
         cyc();
      end
      bus.out_ready = 1'b1;
      wait_idle("full_scan");

      // Partial scans: len 3 and len 9 (clamped to 8).
      for (int k = 0; k < 3; k++) push_beat(16'(16'hA000 + k), 3'(k), k == 2);
      go(1'b1, 3'd0, 4'd3);
      wait_idle("scan3");
      for (int k = 0; k < 8; k++) push_beat(16'(16'hA000 + k), 3'(k), k == 7);
      go(1'b1, 3'd0, 4'd9);
      wait_idle("scan9");

      // Start while busy is ignored; mode/sel changes have no effect.
      bus.out_ready = 1'b0;
      push_beat(16'hA001, 3'd1, 1);
      go(1'b0, 3'd1, 4'd0);
      cyc();
      go(1'b1, 3'd6, 4'd0);
      cyc();
      chk("busy_ign_data", 32'(bus.out_data), 32'hA001);
      bus.out_ready = 1'b1;
      cyc();
      chk("busy_ign_done", 32'(bus.done), 32'd1);
      chk("busy_ign_idle", 32'(bus.busy), 32'd0);
      cyc(); cyc();
      chk("busy_ign_noextra", 32'(bus.out_valid), 32'd0);

      // Start in the done cycle is accepted.
      push_beat(16'hA003, 3'd3, 1);
      go(1'b0, 3'd3, 4'd0);
      for (int n = 0; n < 10 && !bus.done; n++) cyc();
      chk("done_seen", 32'(bus.done), 32'd1);
      push_beat(16'hA004, 3'd4, 1);
      go(1'b0, 3'd4, 4'd0);
      chk("done_start_load", 32'(bus.busy), 32'd1);
      wait_idle("done_start");

      // data_in sampled in LOAD, not at start.
      push_beat(16'h1234, 3'd2, 1);
      go(1'b0, 3'd2, 4'd0);
      bus.data_in[2*DW +: DW] = 16'h1234;
      wait_idle("sample");
      set_chans();

      // Reset during WAIT of the third scan beat, then restart from channel 0.
      bus.out_ready = 1'b0;
      push_beat(16'hA000, 3'd0, 0);
      push_beat(16'hA001, 3'd1, 0);
      go(1'b1, 3'd0, 4'd0);
      for (int b = 0; b < 2; b++) begin
         wait_valid("rst_step");
         bus.out_ready = 1'b1;
         cyc();
         bus.out_ready = 1'b0;
      end
      wait_valid("rst_beat3");
      chk("rst_beat3_data", 32'(bus.out_data), 32'hA002);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_data", 32'(bus.out_data), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) push_beat(16'(16'hA000 + k), 3'(k), k == 2);
      go(1'b1, 3'd0, 4'd3);
      cyc();
      chk("restart_data", 32'(bus.out_data), 32'hA000);
      wait_idle("restart");
      cyc();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
